// File: rtl/cp_fifo_fetch.sv
// rtl/cp_fifo_fetch.sv - CP FIFO read-side fetch engine (AXI AR/R to 32-bit command word stream)
//
// Fetches 32-byte command lines from the circular CP FIFO in host memory,
// one AXI burst at a time. The beats are buffered and then unpacked
// low word first into a 32-bit stream for the command decoder.
//
// Ports:
//   clk, resetn              clock, asynchronous active-low reset
//   enable                   allow new fetches from IDLE
//   fifo_base, fifo_end      FIFO first / last line byte address (bits[4:0] ignored)
//   write_ptr                producer pointer (bits[4:0] ignored)
//   rp_load, rp_load_val     load read pointer and flush buffered data
//   read_ptr, rw_distance    current fetch pointer, bytes pending (registered)
//   bus_error                sticky, set by any nonzero rresp
//   ar*/r*                   AXI read address / read data channels
//   out_data/valid/ready     registered command word stream
module cp_fifo_fetch #(
    parameter int ADDR_W      = 49,
    parameter int BURST_BEATS = 2,
    parameter int BUF_DEPTH   = 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              enable,
    input  logic [31:0]       fifo_base,
    input  logic [31:0]       fifo_end,
    input  logic [31:0]       write_ptr,
    input  logic              rp_load,
    input  logic [31:0]       rp_load_val,
    output logic [31:0]       read_ptr,
    output logic [31:0]       rw_distance,
    output logic              bus_error,
    output logic [ADDR_W-1:0] araddr,
    output logic [7:0]        arlen,
    output logic [2:0]        arsize,
    output logic [1:0]        arburst,
    output logic              arvalid,
    input  logic              arready,
    input  logic [127:0]      rdata,
    input  logic [1:0]        rresp,
    input  logic              rlast,
    input  logic              rvalid,
    output logic              rready,
    output logic [31:0]       out_data,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam int PW = $clog2(BUF_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] BEATS_C = CW'(BURST_BEATS);
    localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_e;

    state_e        state_q, state_d;
    logic          drain_q, drain_d;      // current burst belongs to a flushed pointer
    logic [26:0]   rp_q, rp_d;            // read pointer as a line index
    logic [31:0]   dist_q, dist_d;
    logic          bus_err_q, bus_err_d;
    logic [127:0]  mem_q [BUF_DEPTH];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;          // entries holding data
    logic [CW-1:0] used_q, used_d;        // entries holding data or reserved for the open burst
    logic [1:0]    wsel_q, wsel_d;        // next word within the head entry
    logic          out_valid_q, out_valid_d;
    logic [31:0]   out_data_q, out_data_d;

    logic [26:0]   base_l, end_l, wp_l;
    logic          can_issue, reserve, r_hs, beat_wr, have, retire;
    logic [127:0]  head;
    logic [31:0]   rp_a, wp_a, base_a, end_a;
    logic          unused_bits;

    assign base_l = fifo_base[31:5];
    assign end_l  = fifo_end[31:5];
    assign wp_l   = write_ptr[31:5];
    assign unused_bits = ^{fifo_base[4:0], fifo_end[4:0], write_ptr[4:0], rp_load_val[4:0]};

    // Space is claimed before the AR goes out, so rready never has to drop.
    assign can_issue = enable && (rp_q != wp_l) && ((DEPTH_C - used_q) >= BEATS_C);
    assign reserve   = (state_q == S_IDLE) && !rp_load && can_issue;
    assign r_hs      = (state_q == S_DATA) && rvalid;
    assign beat_wr   = r_hs && !drain_q && !rp_load;

    // FSM and read pointer
    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        rp_d    = rp_q;
        case (state_q)
            S_IDLE: begin
                if (reserve) state_d = S_ADDR;
            end
            S_ADDR: begin
                if (arready) begin
                    state_d = S_DATA;
                    if (!rp_load && !drain_q)
                        rp_d = (rp_q == end_l) ? base_l : rp_q + 27'd1;
                end
            end
            S_DATA: begin
                if (rvalid && rlast) begin
                    state_d = S_IDLE;
                    drain_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (rp_load) begin
            rp_d = rp_load_val[31:5];
            // A burst already requested must still be absorbed, unless it ends now.
            if ((state_q == S_ADDR) || ((state_q == S_DATA) && !(rvalid && rlast)))
                drain_d = 1'b1;
        end
    end

    // Buffer bookkeeping and skid output
    always_comb begin
        wr_d        = wr_q;
        rd_d        = rd_q;
        wsel_d      = wsel_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        retire      = 1'b0;
        bus_err_d   = bus_err_q | (r_hs && (rresp != 2'b00));
        // When the buffer is empty the arriving beat is forwarded directly.
        head        = (cnt_q == '0) ? rdata : mem_q[rd_q];
        have        = (cnt_q != '0) || beat_wr;

        if (out_valid_q && out_ready) out_valid_d = 1'b0;
        if ((!out_valid_q || out_ready) && have) begin
            out_valid_d = 1'b1;
            out_data_d  = head[{wsel_q, 5'b0} +: 32];
            wsel_d      = wsel_q + 2'd1;
            retire      = (wsel_q == 2'd3);
        end
        if (retire)  rd_d = rd_q + PW'(1);
        if (beat_wr) wr_d = wr_q + PW'(1);

        cnt_d  = cnt_q + CW'(beat_wr) - CW'(retire);
        used_d = used_q + (reserve ? BEATS_C : '0) - CW'(retire);

        if (rp_load) begin
            wr_d        = '0;
            rd_d        = '0;
            wsel_d      = '0;
            cnt_d       = '0;
            used_d      = '0;
            out_valid_d = 1'b0;
            out_data_d  = '0;
        end
    end

    // Distance in bytes, accounting for wrap at fifo_end
    always_comb begin
        rp_a   = {rp_q, 5'b0};
        wp_a   = {wp_l, 5'b0};
        base_a = {base_l, 5'b0};
        end_a  = {end_l, 5'b0};
        if (wp_a >= rp_a) dist_d = wp_a - rp_a;
        else              dist_d = (end_a + 32'd32 - rp_a) + (wp_a - base_a);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            drain_q     <= 1'b0;
            rp_q        <= '0;
            dist_q      <= '0;
            bus_err_q   <= 1'b0;
            wr_q        <= '0;
            rd_q        <= '0;
            cnt_q       <= '0;
            used_q      <= '0;
            wsel_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            drain_q     <= drain_d;
            rp_q        <= rp_d;
            dist_q      <= dist_d;
            bus_err_q   <= bus_err_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            cnt_q       <= cnt_d;
            used_q      <= used_d;
            wsel_q      <= wsel_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    // Storage needs no reset; occupancy counters define validity.
    always_ff @(posedge clk) begin
        if (beat_wr) mem_q[wr_q] <= rdata;
    end

    assign read_ptr    = {rp_q, 5'b0};
    assign rw_distance = dist_q;
    assign bus_error   = bus_err_q;
    assign araddr      = ADDR_W'({rp_q, 5'b0});
    assign arlen       = 8'(BURST_BEATS - 1);
    assign arsize      = 3'b100;
    assign arburst     = 2'b01;
    assign arvalid     = (state_q == S_ADDR);
    assign rready      = (state_q == S_DATA);
    assign out_data    = out_data_q;
    assign out_valid   = out_valid_q;

endmodule

// File: doc/cp_fifo_fetch.md
Name: cp_fifo_fetch

Overview:
- Read-side fetch engine for the Command Processor FIFO.
- Pulls 32-byte command lines from the circular CP FIFO in main memory over the full AXI host read channels (AR/R, 128-bit data).
- Buffers the fetched lines and unpacks them into a 32-bit word stream for the CP command decoder.
- Sits between the AXI host port and the command decoder inside the CP. Pointer configuration comes from CP registers.

Parameters:
- ADDR_W, 49: AXI address width; upper bits above 32 are driven zero.
- BURST_BEATS, 2: 128-bit beats per fetch. 2 beats = one 32-byte line.
- BUF_DEPTH, 8: buffer depth in 128-bit entries; power of two, at least BURST_BEATS.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- enable  in  1  fetch enable (CP read enable)
- fifo_base  in  32  FIFO base byte address; bits[4:0] ignored
- fifo_end  in  32  address of the last 32-byte line in the FIFO; bits[4:0] ignored
- write_ptr  in  32  producer write pointer; bits[4:0] ignored
- rp_load  in  1  one-cycle pulse: load read pointer and flush
- rp_load_val  in  32  value for rp_load
- read_ptr  out  32  current fetch pointer, 32-byte aligned
- rw_distance  out  32  bytes between read_ptr and write_ptr, modulo FIFO size
- bus_error  out  1  sticky; set on any nonzero rresp
- araddr  out  ADDR_W  read address
- arlen  out  8  read burst length
- arsize  out  3  read beat size
- arburst  out  2  read burst type
- arvalid  out  1  read address valid
- arready  in  1  read address ready
- rdata  in  128  read data
- rresp  in  2  read response
- rlast  in  1  last beat of burst
- rvalid  in  1  read data valid
- rready  out  1  read data ready
- out_data  out  32  command word
- out_valid  out  1  command word valid
- out_ready  in  1  command word ready

Behaviour:
- Reset values (async, resetn=0): arvalid=0, rready=0, out_valid=0, out_data=0, read_ptr=0, bus_error=0. Buffer is emptied and the FSM goes to IDLE.
- Fixed AXI fields:
  - arlen = BURST_BEATS-1
  - arsize = 3'b100
  - arburst = 2'b01 (INCR)
  - araddr = {zeros, read_ptr[31:5], 5'b0}
- FSM states: IDLE, ADDR, DATA. Only one burst is outstanding at a time.
  - IDLE -> ADDR when enable=1, read_ptr != write_ptr (aligned compare), and the free buffer entries (not counting reserved ones) are at least BURST_BEATS. BURST_BEATS entries are reserved on this transition.
  - ADDR: arvalid=1, held with stable fields until arready. On the handshake: go to DATA, and advance read_ptr to fifo_base if read_ptr == fifo_end, otherwise to read_ptr + 32.
  - DATA: rready=1 continuously, because space is already reserved. Each rvalid beat is written into the buffer. On the rvalid && rlast beat, go to IDLE. A new AR may issue on the cycle after rlast, never the same cycle.
- Clearing enable does not abort an outstanding request. ADDR and DATA complete normally; no new AR issues from IDLE.
- Unpacking: each 128-bit entry emits four words, in the order rdata[31:0], [63:32], [95:64], [127:96]. There is no byte swap.
  - out_valid/out_data is a registered skid output: once out_valid=1, out_data holds until out_ready.
  - With out_ready held high, one word per cycle.
  - First word appears 1 cycle after the beat is accepted.
- rresp != 0: bus_error is set and stays set until reset. The beat is still stored and forwarded.
- rw_distance:
  - write_ptr >= read_ptr: write_ptr - read_ptr
  - otherwise: (fifo_end + 32 - read_ptr) + (write_ptr - fifo_base)
  - Computed on aligned values, registered, valid 1 cycle after any change.
- rp_load (takes priority over all events in the same cycle):
  - read_ptr is loaded with the aligned rp_load_val.
  - Buffer, reservations and the output register are cleared, so out_valid=0 the next cycle.
  - If in ADDR: complete the address handshake, then drain.
  - If in DATA: keep rready=1 and discard the remaining beats through rlast. read_ptr is not advanced for a discarded burst.
  - No new AR issues until the drain completes.
- Simultaneous buffer write (R beat) and entry retire (last word accepted) in the same cycle: occupancy stays unchanged.
- The buffer never overflows, because of the reservation scheme.
- read_ptr == write_ptr means empty. The producer must not fill the FIFO completely.

Test Plan:
- Linear fetch: base=0x1000, end=0x10E0, rp_load 0x1000, write_ptr=0x1040, enable=1, out_ready=1.
  -> ARs at 0x1000 then 0x1020, arlen=1, arsize=4, arburst=1.
  -> 16 words in address order; read_ptr=0x1040; no third AR.
- Wrap: rp_load 0x10E0, write_ptr=0x1020.
  -> rw_distance=0x40.
  -> ARs at 0x10E0 then 0x1000; read_ptr=0x1020, rw_distance=0.
- Backpressure: out_ready=0, distance 0x200, BUF_DEPTH=8.
  -> exactly 4 bursts issue, then arvalid stays 0.
  -> After 8 words are accepted (2 entries freed), one more AR issues.
- Error response: rresp=2'b10 on beat 1 of the 0x1000 burst.
  -> bus_error=1 and stays 1.
  -> All 8 words of the line are still delivered.
- Flush mid-burst: rp_load 0x1080 after beat 0 of the 0x1000 burst is accepted.
  -> out_valid=0 next cycle; beat 1 is discarded.
  -> Next AR=0x1080; first word out is from 0x1080.
- Reset mid-burst: resetn=0 while in DATA.
  -> arvalid, rready, out_valid, bus_error = 0 immediately (asynchronous); read_ptr=0.
  -> Fetching restarts only after rp_load and enable.
